utc_local_time_conv: RTL



---
 rtl/utc_local_time_conv.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/utc_local_time_conv.sv
// Binary hhmmss UTC to local-time BCD converter with timezone offset and day rollover; TIME_DST_EN adds a dst input.
// Latency N+1 cycles (N = sum of digits above sec_u + 5); in_valid is ignored while busy (no queue, no backpressure).
module utc_local_time_conv #(
    parameter int TZ_OFFSET = 8,
    parameter int IN_W      = 18
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [IN_W-1:0] utc_hhmmss,
`ifdef TIME_DST_EN
    input  logic            dst,
`endif
    output logic            busy,
    output logic            out_valid,
    output logic [3:0]      hour_t,
    output logic [3:0]      hour_u,
    output logic [3:0]      min_t,
    output logic [3:0]      min_u,
    output logic [3:0]      sec_t,
    output logic [3:0]      sec_u,
    output logic            day_inc,
    output logic            err
);

    if (TZ_OFFSET < 0 || TZ_OFFSET > 23) begin : g_bad_tz
        $error("TZ_OFFSET must be within 0..23");
    end
    if (IN_W < 18 || IN_W > 20) begin : g_bad_inw
        $error("IN_W must be within 18..20");
    end

    typedef enum logic [1:0] {IDLE, DIV, ADJ} state_t;

    state_t          state_q, state_d;
    logic [IN_W-1:0] rem_q, rem_d;
    logic [2:0]      widx_q, widx_d;
    logic [4:0][3:0] cnt_q, cnt_d;
    logic            dst_q, dst_d;
    logic            busy_q, busy_d;
    logic            out_valid_q, out_valid_d;
    logic [5:0][3:0] dig_q, dig_d;
    logic            day_inc_q, day_inc_d;
    logic            err_q, err_d;

    logic            dst_in;
    logic [IN_W-1:0] cur_w;
    logic [6:0]      h, m, s;
    logic [5:0]      hl;
    logic            bad;

`ifdef TIME_DST_EN
    assign dst_in = dst;
`else
    assign dst_in = 1'b0;
`endif

    // Weight index 0..4 walks hour_t down to sec_t; the leftover remainder is sec_u.
    always_comb begin
        cur_w = IN_W'(17'd10);
        case (widx_q)
            3'd0:    cur_w = IN_W'(17'd100000);
            3'd1:    cur_w = IN_W'(17'd10000);
            3'd2:    cur_w = IN_W'(17'd1000);
            3'd3:    cur_w = IN_W'(17'd100);
            default: cur_w = IN_W'(17'd10);
        endcase
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        widx_d      = widx_q;
        cnt_d       = cnt_q;
        dst_d       = dst_q;
        busy_d      = busy_q;
        out_valid_d = 1'b0;
        dig_d       = dig_q;
        day_inc_d   = day_inc_q;
        err_d       = err_q;
        h           = 7'd0;
        m           = 7'd0;
        s           = 7'd0;
        hl          = 6'd0;
        bad         = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    rem_d   = utc_hhmmss;
                    cnt_d   = '0;
                    widx_d  = 3'd0;
                    dst_d   = dst_in;
                    busy_d  = 1'b1;
                    state_d = DIV;
                end
            end
            DIV: begin
                if (rem_q >= cur_w) begin
                    rem_d         = rem_q - cur_w;
                    cnt_d[widx_q] = cnt_q[widx_q] + 4'd1;
                end else if (widx_q == 3'd4) begin
                    state_d = ADJ;
                end else begin
                    widx_d = widx_q + 3'd1;
                end
            end
            ADJ: begin
                // h is 7 bits so an out-of-range hour_t of 10 cannot alias into a legal hour.
                h   = 7'(cnt_q[0]) * 7'd10 + 7'(cnt_q[1]);
                m   = 7'(cnt_q[2]) * 7'd10 + 7'(cnt_q[3]);
                s   = 7'(cnt_q[4]) * 7'd10 + 7'(rem_q[3:0]);
                bad = (h > 7'd23) || (m > 7'd59) || (s > 7'd59);
                if (bad) begin
                    dig_d     = '0;
                    day_inc_d = 1'b0;
                    err_d     = 1'b1;
                end else begin
                    hl        = h[5:0] + 6'(TZ_OFFSET) + {5'd0, dst_q};
                    day_inc_d = 1'b0;
                    if (hl >= 6'd24) begin
                        hl        = hl - 6'd24;
                        day_inc_d = 1'b1;
                    end
                    if (hl >= 6'd20) begin
                        dig_d[5] = 4'd2;
                        dig_d[4] = 4'(hl - 6'd20);
                    end else if (hl >= 6'd10) begin
                        dig_d[5] = 4'd1;
                        dig_d[4] = 4'(hl - 6'd10);
                    end else begin
                        dig_d[5] = 4'd0;
                        dig_d[4] = hl[3:0];
                    end
                    dig_d[3] = cnt_q[2];
                    dig_d[2] = cnt_q[3];
                    dig_d[1] = cnt_q[4];
                    dig_d[0] = rem_q[3:0];
                    err_d    = 1'b0;
                end
                out_valid_d = 1'b1;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            widx_q      <= 3'd0;
            cnt_q       <= '0;
            dst_q       <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            dig_q       <= '0;
            day_inc_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            widx_q      <= widx_d;
            cnt_q       <= cnt_d;
            dst_q       <= dst_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            dig_q       <= dig_d;
            day_inc_q   <= day_inc_d;
            err_q       <= err_d;
        end
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign hour_t    = dig_q[5];
    assign hour_u    = dig_q[4];
    assign min_t     = dig_q[3];
    assign min_u     = dig_q[2];
    assign sec_t     = dig_q[1];
    assign sec_u     = dig_q[0];
    assign day_inc   = day_inc_q;
    assign err       = err_q;

endmodule
